// File: rtl/display_arbiter_if.sv
// Display bus between the content sources and the arbiter: requests and words in,
// owner grant and the selected display word out.
interface display_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*24-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic [23:0]        disp;
    logic               disp_own;

    modport master (output req, req_data, input grant, disp, disp_own);
    modport slave  (input req, req_data, output grant, disp, disp_own);
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of the 6-digit display bus with a minimum hold time per grant;
// shows IDLE_CODE when no source wants the display.
module display_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned TIMER_W     = 4,
    parameter logic [23:0] IDLE_CODE   = 24'hDDDDDD
) (
    input  logic               clk,
    input  logic               reset,
    display_arbiter_if.slave   bus
);
    localparam int unsigned DW    = 24;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t             r_state, w_state_nxt;
    logic [NREQ-1:0]    r_grant, w_grant_nxt;
    logic [DW-1:0]      r_disp,  w_disp_nxt;
    logic               r_own,   w_own_nxt;
    logic [IDX_W-1:0]   r_last,  w_last_nxt;
    logic [TIMER_W-1:0] r_cnt,   w_cnt_nxt;

    logic [NREQ-1:0]    w_cand;
    logic               w_pick_vld;
    logic [IDX_W-1:0]   w_pick;
    logic [DW-1:0]      w_pick_data;
    logic [DW-1:0]      w_own_data;
    logic               w_own_req;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned k);
        return IDX_W'((32'(base) + k) % NREQ);
    endfunction

    // r_last always names the current owner while in S_OWN
    assign w_cand      = (r_state == S_OWN) ? (bus.req & ~r_grant) : bus.req;
    assign w_own_req   = |(bus.req & r_grant);
    assign w_own_data  = bus.req_data[DW*32'(r_last) +: DW];
    assign w_pick_data = bus.req_data[DW*32'(w_pick) +: DW];

    // Round-robin scan starting just after the previous winner
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!w_pick_vld && w_cand[rr_idx(r_last, k)]) begin
                w_pick_vld = 1'b1;
                w_pick     = rr_idx(r_last, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_disp_nxt  = r_disp;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = NREQ'(1) << w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_disp_nxt  = w_pick_data;
                    w_own_nxt   = 1'b1;
                end
            end
            S_OWN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - TIMER_W'(1);
                    if (w_own_req) w_disp_nxt = w_own_data;
                end else if (w_pick_vld) begin
                    w_grant_nxt = NREQ'(1) << w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_disp_nxt  = w_pick_data;
                end else if (w_own_req) begin
                    w_disp_nxt = w_own_data;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_disp_nxt  = IDLE_CODE;
                    w_own_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_disp  <= IDLE_CODE;
            r_own   <= 1'b0;
            r_last  <= IDX_W'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_disp  <= w_disp_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.disp     = r_disp;
    assign bus.disp_own = r_own;
endmodule

// File: tb/tb_display_arbiter.sv
// Checks two arbiters (hold 8 and hold 1) against an owner/age reference model
// under directed scenarios followed by random request and data traffic.
module tb_display_arbiter;
    localparam int unsigned NREQ = 3;
    localparam logic [23:0] IDLE = 24'hDDDDDD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NREQ-1:0] req;
    logic [23:0]     data [NREQ];

    display_arbiter_if #(.NREQ(NREQ)) bus8 ();
    display_arbiter_if #(.NREQ(NREQ)) bus1 ();

    assign bus8.req      = req;
    assign bus8.req_data = {data[2], data[1], data[0]};
    assign bus1.req      = req;
    assign bus1.req_data = {data[2], data[1], data[0]};

    display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(8), .TIMER_W(4), .IDLE_CODE(IDLE))
        dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
    display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(1), .TIMER_W(1), .IDLE_CODE(IDLE))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference: owner index (-1 = idle), cycles elapsed since the grant edge
    int          m_owner [2];
    int          m_last  [2];
    int          m_age   [2];
    logic [23:0] m_disp  [2];
    int          m_hold  [2] = '{8, 1};

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r, input int excl);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int i;
            i = (last + k) % int'(NREQ);
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_last[m]  = int'(NREQ) - 1;
            m_age[m]   = 0;
            m_disp[m]  = IDLE;
        end
    endtask

    task automatic model_grant(input int m, input int p);
        m_owner[m] = p;
        m_last[m]  = p;
        m_age[m]   = 0;
        m_disp[m]  = data[p];
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            int p;
            if (m_owner[m] < 0) begin
                p = rr_pick(m_last[m], req, -1);
                if (p >= 0) model_grant(m, p);
            end else if (m_age[m] < m_hold[m] - 1) begin
                m_age[m]++;
                if (req[m_owner[m]]) m_disp[m] = data[m_owner[m]];
            end else begin
                p = rr_pick(m_last[m], req, m_owner[m]);
                if (p >= 0) model_grant(m, p);
                else if (req[m_owner[m]]) m_disp[m] = data[m_owner[m]];
                else begin
                    m_owner[m] = -1;
                    m_disp[m]  = IDLE;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_grant(input int m);
        return (m_owner[m] < 0) ? 32'd0 : (32'd1 << m_owner[m]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_grant8"}, 32'(bus8.grant), exp_grant(0));
        chk({tag, "_disp8"},  32'(bus8.disp), 32'(m_disp[0]));
        chk({tag, "_own8"},   32'(bus8.disp_own), 32'(m_owner[0] >= 0));
        chk({tag, "_grant1"}, 32'(bus1.grant), exp_grant(1));
        chk({tag, "_disp1"},  32'(bus1.disp), 32'(m_disp[1]));
        chk({tag, "_own1"},   32'(bus1.disp_own), 32'(m_owner[1] >= 0));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick("rst");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < int'(NREQ); i++) data[i] = 24'h0;
        model_reset();

        // Reset held with all requests active
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick("t1");
            chk("t1_grant", 32'(bus8.grant), 32'd0);
            chk("t1_disp", 32'(bus8.disp), 32'(IDLE));
        end

        // Single source and live data tracking
        do_reset();
        req = 3'b001; data[0] = 24'h123456;
        tick("t2a");
        chk("t2_grant", 32'(bus8.grant), 32'd1);
        chk("t2_disp", 32'(bus8.disp), 32'h123456);
        data[0] = 24'h654321;
        tick("t2b");
        chk("t2_track", 32'(bus8.disp), 32'h654321);

        // Two sources alternate every 8 cycles with no idle gap
        do_reset();
        req = 3'b011; data[0] = 24'h000111; data[1] = 24'h111000;
        for (int i = 0; i < 17; i++) begin
            tick("t3");
            chk("t3_grant", 32'(bus8.grant), (i < 8) ? 32'd1 : (i < 16) ? 32'd2 : 32'd1);
        end

        // Owner drops early: display frozen until expiry, then idle
        do_reset();
        req = 3'b001; data[0] = 24'hAAAAAA;
        tick("t4a");
        tick("t4b");
        req = 3'b000; data[0] = 24'hBBBBBB;
        for (int i = 0; i < 6; i++) begin
            tick("t4c");
            chk("t4_frozen", 32'(bus8.disp), 32'hAAAAAA);
            chk("t4_hold", 32'(bus8.grant), 32'd1);
        end
        tick("t4d");
        chk("t4_idle", 32'(bus8.disp), 32'(IDLE));

        // Lone owner keeps the display; newcomer takes over at the next edge
        do_reset();
        req = 3'b100; data[2] = 24'h222222;
        for (int i = 0; i < 40; i++) begin
            tick("t5a");
            chk("t5_lone", 32'(bus8.grant), 32'd4);
        end
        req = 3'b101; data[0] = 24'h000000;
        tick("t5b");
        chk("t5_handoff", 32'(bus8.grant), 32'd1);

        // Asynchronous reset in the middle of a hold
        do_reset();
        req = 3'b011;
        tick("t6a"); tick("t6b"); tick("t6c");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("t6async");
        chk("t6_grant", 32'(bus8.grant), 32'd0);
        tick("t6d");
        reset = 1'b0;
        req = 3'b110;
        tick("t6e");
        chk("t6_first", 32'(bus8.grant), 32'd2);

        // Random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3, 0) == 0) req[$urandom_range(NREQ - 1, 0)] ^= 1'b1;
            for (int i = 0; i < int'(NREQ); i++)
                if ($urandom_range(1, 0) == 1) data[i] = 24'($urandom);
            reset = ($urandom_range(199, 0) == 0);
            tick("rnd");
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
